llmint8_outlier_gather: RTL and testbench



---
 rtl/llmint8_outlier_gather.sv | 137 +++++++++++++
 tb/tb_llmint8_outlier_gather.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/llmint8_outlier_gather.sv
`default_nettype none
// ============================================================================
// Module      : llmint8_outlier_gather
// Description : Merges the high-precision and int8 result streams element by
//               element, steered by buffered per-element outlier masks.
// Revision    : 1.0 - initial release
// ============================================================================
module llmint8_outlier_gather #(
    parameter int PARALLELISM = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SMALL_WIDTH = 8,
    parameter int FRAC_WIDTH  = 0,
    parameter int MASK_DEPTH  = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PARALLELISM-1:0]            mask_in,
    input  logic                              mask_in_valid,
    output logic                              mask_in_ready,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] data_in_large,
    input  logic                              data_in_large_valid,
    output logic                              data_in_large_ready,
    input  logic [PARALLELISM*SMALL_WIDTH-1:0] data_in_small,
    input  logic                              data_in_small_valid,
    output logic                              data_in_small_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0] data_out,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic [CNT_WIDTH-1:0]              outlier_count
);

    localparam int c_ptr_w = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;
    localparam int c_occ_w = c_ptr_w + 1;
    localparam int c_pc_w  = $clog2(PARALLELISM + 1);

    // Both inputs and the output share FRAC_WIDTH, so no realignment is needed.
    localparam int c_frac_unused = FRAC_WIDTH;

    logic [PARALLELISM-1:0]            r_mask_mem [MASK_DEPTH];
    logic [c_ptr_w-1:0]                r_wr_ptr;
    logic [c_ptr_w-1:0]                r_rd_ptr;
    logic [c_occ_w-1:0]                r_occ;
    logic [PARALLELISM*DATA_WIDTH-1:0] r_data_out;
    logic                              r_out_valid;
    logic [CNT_WIDTH-1:0]              r_count;

    logic                              w_full;
    logic                              w_nonempty;
    logic                              w_out_free;
    logic                              w_data_ready;
    logic                              w_push;
    logic                              w_fire;
    logic [PARALLELISM-1:0]            w_head;
    logic [PARALLELISM*DATA_WIDTH-1:0] w_merged;
    logic [c_pc_w-1:0]                 w_popcnt;
    logic [CNT_WIDTH:0]                w_sum;

    assign w_full       = (r_occ == c_occ_w'(MASK_DEPTH));
    assign w_nonempty   = (r_occ != '0);
    assign w_out_free   = !r_out_valid || data_out_ready;
    assign w_data_ready = w_nonempty && w_out_free && !rst;
    assign w_push       = mask_in_valid && mask_in_ready;
    assign w_fire       = w_data_ready && data_in_large_valid && data_in_small_valid;
    assign w_head       = r_mask_mem[r_rd_ptr];

    assign mask_in_ready       = !w_full && !rst;
    assign data_in_large_ready = w_data_ready;
    assign data_in_small_ready = w_data_ready;

    generate
        for (genvar i = 0; i < PARALLELISM; i++) begin : g_elem
            logic signed [SMALL_WIDTH-1:0] w_small;
            logic        [DATA_WIDTH-1:0]  w_small_ext;
            assign w_small     = data_in_small[i*SMALL_WIDTH +: SMALL_WIDTH];
            assign w_small_ext = DATA_WIDTH'(w_small);
            assign w_merged[i*DATA_WIDTH +: DATA_WIDTH] =
                w_head[i] ? data_in_large[i*DATA_WIDTH +: DATA_WIDTH] : w_small_ext;
        end
    endgenerate

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            w_popcnt = w_popcnt + c_pc_w'(w_head[i]);
        end
    end

    // One extra bit catches overflow so the counter can pin at all-ones.
    assign w_sum = {1'b0, r_count} + (CNT_WIDTH + 1)'(w_popcnt);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask_mem[r_wr_ptr] <= mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_fire})
                2'b10:   r_occ <= r_occ + c_occ_w'(1);
                2'b01:   r_occ <= r_occ - c_occ_w'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else if (w_fire) begin
            r_data_out  <= w_merged;
            r_out_valid <= 1'b1;
            r_count     <= w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
        end else if (r_out_valid && data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_out_valid;
    assign outlier_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_llmint8_outlier_gather.sv
`default_nettype none
// ============================================================================
// Module      : tb_llmint8_outlier_gather
// Description : Directed self-checking bench for llmint8_outlier_gather.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llmint8_outlier_gather;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mask_in;
    logic        mask_in_valid;
    logic        mask_in_ready;
    logic [63:0] data_in_large;
    logic        data_in_large_valid;
    logic        data_in_large_ready;
    logic [31:0] data_in_small;
    logic        data_in_small_valid;
    logic        data_in_small_ready;
    logic [63:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic [31:0] outlier_count;

    int n_checks = 0;
    int n_fail   = 0;

    llmint8_outlier_gather dut (
        .clk                 (clk),
        .rst                 (rst),
        .mask_in             (mask_in),
        .mask_in_valid       (mask_in_valid),
        .mask_in_ready       (mask_in_ready),
        .data_in_large       (data_in_large),
        .data_in_large_valid (data_in_large_valid),
        .data_in_large_ready (data_in_large_ready),
        .data_in_small       (data_in_small),
        .data_in_small_valid (data_in_small_valid),
        .data_in_small_ready (data_in_small_ready),
        .data_out            (data_out),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .outlier_count       (outlier_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lv(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    function automatic logic [31:0] sv8(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mask(input logic [3:0] m);
        mask_in       = m;
        mask_in_valid = 1'b1;
        tick();
        mask_in_valid = 1'b0;
    endtask

    task automatic set_valids(input logic v);
        data_in_large_valid = v;
        data_in_small_valid = v;
    endtask

    task automatic beat_check(input string tag, input logic [63:0] exp_out, input logic [31:0] exp_cnt);
        tick();
        check({tag, "_valid"}, 64'(data_out_valid), 64'd1);
        check({tag, "_data"}, data_out, exp_out);
        check({tag, "_count"}, 64'(outlier_count), 64'(exp_cnt));
    endtask

    logic [63:0] c_large;
    logic [31:0] c_small;
    logic [63:0] held;

    initial begin
        rst = 1'b1;
        mask_in = '0; mask_in_valid = 1'b0;
        data_in_large = '0; data_in_small = '0;
        set_valids(1'b0);
        data_out_ready = 1'b1;
        c_large = lv(100, 200, 300, 400);
        c_small = sv8(-1, -2, -3, -4);

        // Reset state, readies low while rst is high
        tick(); tick();
        check("rst_valid", 64'(data_out_valid), 64'd0);
        check("rst_data", data_out, 64'd0);
        check("rst_count", 64'(outlier_count), 64'd0);
        check("rst_mask_rdy", 64'(mask_in_ready), 64'd0);
        check("rst_large_rdy", 64'(data_in_large_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_mask_rdy", 64'(mask_in_ready), 64'd1);
        check("post_rst_data_rdy", 64'(data_in_small_ready), 64'd0);

        // Basic merge
        push_mask(4'b0101);
        check("basic_rdy", 64'(data_in_large_ready), 64'd1);
        data_in_large = lv(1000, -2000, 3000, -4000);
        data_in_small = sv8(5, -6, 7, -8);
        set_valids(1'b1);
        beat_check("basic", {16'hFFF8, 16'h0BB8, 16'hFFFA, 16'h03E8}, 32'd2);
        set_valids(1'b0);
        tick();
        check("basic_drain", 64'(data_out_valid), 64'd0);

        // Ordering and full
        push_mask(4'b0001); push_mask(4'b0011); push_mask(4'b0111); push_mask(4'b1111);
        check("full_mask_rdy", 64'(mask_in_ready), 64'd0);
        data_in_large = c_large;
        data_in_small = c_small;
        set_valids(1'b1);
        beat_check("ord0", {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'h0064}, 32'd3);
        check("ord_mask_rdy", 64'(mask_in_ready), 64'd1);
        beat_check("ord1", {16'hFFFC, 16'hFFFD, 16'h00C8, 16'h0064}, 32'd5);
        beat_check("ord2", {16'hFFFC, 16'h012C, 16'h00C8, 16'h0064}, 32'd8);
        beat_check("ord3", {16'h0190, 16'h012C, 16'h00C8, 16'h0064}, 32'd12);
        set_valids(1'b0);
        check("ord_empty_rdy", 64'(data_in_large_ready), 64'd0);

        // Backpressure
        push_mask(4'b1000); push_mask(4'b0100);
        data_out_ready = 1'b0;
        set_valids(1'b1);
        beat_check("bp0", {16'h0190, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 32'd13);
        held = data_out;
        for (int k = 0; k < 3; k++) begin
            check("bp_large_rdy", 64'(data_in_large_ready), 64'd0);
            check("bp_small_rdy", 64'(data_in_small_ready), 64'd0);
            tick();
            check("bp_hold", data_out, {16'h0190, 16'hFFFD, 16'hFFFE, 16'hFFFF});
        end
        data_out_ready = 1'b1;
        beat_check("bp1", {16'hFFFC, 16'h012C, 16'hFFFE, 16'hFFFF}, 32'd14);
        tick();
        check("bp_nodup_valid", 64'(data_out_valid), 64'd0);
        check("bp_nodup_count", 64'(outlier_count), 64'd14);
        set_valids(1'b0);

        // Stream skew
        push_mask(4'b0010);
        data_in_small = sv8(10, 20, 30, 40);
        data_in_large_valid = 1'b1;
        tick(); tick();
        check("skew_nofire", 64'(data_out_valid), 64'd0);
        check("skew_count", 64'(outlier_count), 64'd14);
        data_in_small_valid = 1'b1;
        beat_check("skew", {16'h0028, 16'h001E, 16'h00C8, 16'h000A}, 32'd15);
        set_valids(1'b0);
        data_in_small = c_small;

        // Full plus simultaneous pop
        push_mask(4'b0001); push_mask(4'b0010); push_mask(4'b0100); push_mask(4'b1000);
        mask_in = 4'b1111;
        mask_in_valid = 1'b1;
        set_valids(1'b1);
        #1;
        check("fullpop_mask_rdy", 64'(mask_in_ready), 64'd0);
        beat_check("fp0", {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'h0064}, 32'd16);
        mask_in_valid = 1'b0;
        check("fp_after_rdy", 64'(mask_in_ready), 64'd1);
        beat_check("fp1", {16'hFFFC, 16'hFFFD, 16'h00C8, 16'hFFFF}, 32'd17);
        beat_check("fp2", {16'hFFFC, 16'h012C, 16'hFFFE, 16'hFFFF}, 32'd18);
        beat_check("fp3", {16'h0190, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 32'd19);
        check("fp_empty_rdy", 64'(data_in_small_ready), 64'd0);
        set_valids(1'b0);

        // Reset mid-operation
        push_mask(4'b1111); push_mask(4'b1111);
        data_out_ready = 1'b0;
        set_valids(1'b1);
        beat_check("mid", {16'h0190, 16'h012C, 16'h00C8, 16'h0064}, 32'd23);
        set_valids(1'b0);
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(data_out_valid), 64'd0);
        check("midrst_count", 64'(outlier_count), 64'd0);
        check("midrst_data", data_out, 64'd0);
        rst = 1'b0;
        data_out_ready = 1'b1;
        #1;
        check("midrst_empty_rdy", 64'(data_in_large_ready), 64'd0);
        check("midrst_mask_rdy", 64'(mask_in_ready), 64'd1);
        push_mask(4'b0000);
        set_valids(1'b1);
        beat_check("fresh", {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 32'd0);
        set_valids(1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
